// File: rtl/fft8_bitrev_loader.sv
// Input stage of the 8-point radix-2 DIT FFT: bit-reversed frame buffer feeding the stage-1 butterflies.
// Optional double buffering is enabled with `define FFT8_LOADER_PINGPONG_EN.
module fft8_bitrev_loader #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_A_real,
  output logic [DATA_WIDTH-1:0] out_B_real,
  output logic [DATA_WIDTH-1:0] out_W_real,
  output logic [DATA_WIDTH-1:0] out_W_imag,
  output logic [1:0]            out_idx,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

`ifdef FFT8_LOADER_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Both ports use valid/ready: a word moves on a rising edge where valid && ready are both high;
  // the sender holds valid and data stable until that edge, the receiver may toggle ready freely.

  logic [DATA_WIDTH-1:0] mem_q [16];

  logic [0:0]            state_q, state_d;
  logic [2:0]            wr_cnt_q, wr_cnt_d;
  logic [1:0]            rd_cnt_q, rd_cnt_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  last_q, last_d;

  logic       in_fire, out_fire, frame_done, drain_done;
  logic [3:0] wr_addr, rd_addr_a, rd_addr_b;

  always_comb begin
    in_fire    = in_valid && in_ready_q;
    out_fire   = (state_q == ST_DRAIN) && out_ready;
    frame_done = in_fire && (wr_cnt_q == 3'd7);
    drain_done = out_fire && (rd_cnt_q == 2'd3);

    wr_cnt_d  = in_fire  ? wr_cnt_q + 3'd1 : wr_cnt_q;
    rd_cnt_d  = out_fire ? rd_cnt_q + 2'd1 : rd_cnt_q;
    wr_bank_d = wr_bank_q ^ (frame_done & PINGPONG);
    rd_bank_d = rd_bank_q ^ (drain_done & PINGPONG);

    full_d = full_q;
    if (drain_done) full_d[rd_bank_q] = 1'b0;
    if (frame_done) full_d[wr_bank_q] = 1'b1;

    in_ready_d = !full_d[wr_bank_d];
    state_d    = full_d[rd_bank_d] ? ST_DRAIN : ST_LOAD;

    wr_addr = {wr_bank_q, wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2]};
    // x[k] sits at bitrev3(k) = 2*bitrev2(k); x[k+4] is the odd neighbour of that slot.
    rd_addr_a = {rd_bank_d, rd_cnt_d[0], rd_cnt_d[1], 1'b0};
    rd_addr_b = {rd_bank_d, rd_cnt_d[0], rd_cnt_d[1], 1'b1};

    a_d    = a_q;
    b_d    = b_q;
    last_d = last_q;
    // Pair 0 reads slots 0/1 only, so the 8th sample landing this cycle (slot 7) is never needed yet.
    if ((state_d == ST_DRAIN) && ((state_q == ST_LOAD) || out_fire)) begin
      a_d    = mem_q[rd_addr_a];
      b_d    = mem_q[rd_addr_b];
      last_d = (rd_cnt_d == 2'd3);
    end else if (state_d == ST_LOAD) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      wr_cnt_q   <= 3'd0;
      rd_cnt_q   <= 2'd0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      in_ready_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      in_ready_q <= in_ready_d;
      a_q        <= a_d;
      b_q        <= b_d;
      last_q     <= last_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == ST_DRAIN);
  assign out_A_real = a_q;
  assign out_B_real = b_q;
  assign out_idx    = rd_cnt_q;
  assign out_last   = last_q;
  assign out_W_real = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  assign out_W_imag = '0;

endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// Randomized bench for fft8_bitrev_loader against a frame-level reference model.
module tb_fft8_bitrev_loader;

`ifdef FFT8_LOADER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_A_real, out_B_real, out_W_real, out_W_imag;
  logic [1:0]  out_idx;
  logic        out_last, out_valid;
  logic        out_ready = 1'b0;

  fft8_bitrev_loader #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_A_real(out_A_real), .out_B_real(out_B_real), .out_W_real(out_W_real),
    .out_W_imag(out_W_imag), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard: {idx[1:0], last, A[15:0], B[15:0]}
  logic [34:0] exp_q[$];
  logic [15:0] src_q[$];
  logic [15:0] cur_frame[8];
  int          cur_n = 0;
  int          pending = 0;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model and output checker, evaluated between clock edges.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("in_ready", in_ready, pending < CAP);
      check_eq("out_valid", out_valid, pending > 0);
      check_eq("w_real", out_W_real, 16'h7FFF);
      check_eq("w_imag", out_W_imag, 16'h0000);
      if (out_valid) begin
        check_eq("exp_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check_eq("pair_idx", out_idx, exp_q[0][34:33]);
          check_eq("pair_last", out_last, exp_q[0][32]);
          check_eq("pair_A", out_A_real, exp_q[0][31:16]);
          check_eq("pair_B", out_B_real, exp_q[0][15:0]);
          if (out_ready) begin
            if (exp_q[0][32]) pending--;
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        cur_frame[cur_n] = in_data;
        cur_n++;
        if (cur_n == 8) begin
          for (int k = 0; k < 4; k++) begin
            logic [1:0] kk;
            kk = k[1:0];
            exp_q.push_back({kk, (k == 3), cur_frame[k], cur_frame[k+4]});
          end
          pending++;
          cur_n = 0;
        end
      end
    end
  end

  task automatic apply_reset();
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    src_q.delete();
    exp_q.delete();
    pending  = 0;
    cur_n    = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_A", out_A_real, 0);
    check_eq("rst_out_B", out_B_real, 0);
    check_eq("rst_w_real", out_W_real, 16'h7FFF);
    check_eq("rst_w_imag", out_W_imag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  // One clock of driving; rmode 0=random, 1=always ready, 2=toggle, 3=never ready.
  task automatic step(input int vprob, input int rmode);
    bit taken;
    @(negedge clk);
    taken = in_valid && in_ready;
    @(posedge clk); #1;
    if (taken) begin
      void'(src_q.pop_front());
      in_valid = 1'b0;
    end
    if (!in_valid && src_q.size() > 0 && $urandom_range(99) < vprob) begin
      in_valid = 1'b1;
      in_data  = src_q[0];
    end
    case (rmode)
      0: out_ready = $urandom_range(1);
      1: out_ready = 1'b1;
      2: out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic run_until_idle(input int vprob, input int rmode, input int max_cyc);
    int cyc = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || in_valid) && cyc < max_cyc) begin
      step(vprob, rmode);
      cyc++;
    end
    check_eq("idle_reached", cyc < max_cyc, 1);
  endtask

  task automatic push_ramp(input int first, input int count, input int sgn);
    for (int i = 0; i < count; i++) src_q.push_back(16'(sgn * (first + i)));
  endtask

  initial begin
    apply_reset();

    push_ramp(1, 8, 1);
    run_until_idle(100, 1, 200);

    push_ramp(1, 8, 1);
    run_until_idle(100, 2, 200);

    push_ramp(1, 8, -1);
    run_until_idle(100, 1, 200);

    // Abort after five accepted samples; the following frame must start fresh.
    push_ramp(1, 8, 1);
    for (int i = 0; i < 50 && cur_n < 5; i++) step(100, 1);
    check_eq("partial_frame_reached", cur_n, 5);
    apply_reset();
    push_ramp(10, 8, 1);
    run_until_idle(100, 1, 200);

    push_ramp(1, 16, 1);
    run_until_idle(100, 1, 300);

    // Abort mid-drain with the consumer stalled.
    push_ramp(20, 8, 1);
    for (int i = 0; i < 14; i++) step(100, 3);
    apply_reset();
    push_ramp(30, 8, 1);
    run_until_idle(100, 0, 300);

    for (int i = 0; i < 48; i++) src_q.push_back(16'($urandom));
    run_until_idle(80, 0, 2000);
    for (int i = 0; i < 32; i++) src_q.push_back(16'($urandom));
    run_until_idle(100, 1, 2000);
    for (int i = 0; i < 40; i++) src_q.push_back(16'($urandom));
    run_until_idle($urandom_range(30, 100), 0, 3000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
